// File: rtl/bitty_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : bitty_timer_if
// Description : Data-memory-port bus that the core shares between RAM and
//               the bitty_timer. The master (core) drives the strobe, address,
//               byte enables and write data. The slave (timer) returns
//               combinational read data and the registered interrupt.
// Ports       : ce_i, we_i, addr_i[31:0], sel_i[3:0], data_i[31:0]
//               (master -> slave); data_o[31:0], irq_o (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface bitty_timer_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, irq_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, irq_o
  );
endinterface
`default_nettype wire

// File: rtl/bitty_timer.sv
`default_nettype none
// ============================================================================
// Module      : bitty_timer
// Description : Memory-mapped machine timer. It has a 64-bit mtime counter
//               with a 16-bit prescaler and a 64-bit mtimecmp register. It
//               raises a registered level interrupt while
//               IE && mtime >= mtimecmp. Reads are combinational (0 latency).
//               Writes are byte-enabled and take effect at the clock edge.
// Ports       : clk  - system clock (rising edge)
//               rst  - synchronous active-low reset
//               bus  - bitty_timer_if.slave (ce/we/addr/sel/data in,
//                      data_o read data out, irq_o interrupt out)
// Registers   : 0x00 MTIME_LO, 0x04 MTIME_HI (reads shadow), 0x08 CMP_LO,
//               0x0C CMP_HI, 0x10 CTRL{IE,EN}, 0x14 PRESCALE[15:0],
//               0x18 STATUS{mtime>=cmp}
// Revision    : 1.0 - initial release
// ============================================================================
module bitty_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  wire logic    clk,
  input  wire logic    rst,
  bitty_timer_if.slave bus
);

  // Word offsets (addr_i[7:2])
  localparam logic [5:0] C_OFF_MTIME_LO = 6'd0;
  localparam logic [5:0] C_OFF_MTIME_HI = 6'd1;
  localparam logic [5:0] C_OFF_CMP_LO   = 6'd2;
  localparam logic [5:0] C_OFF_CMP_HI   = 6'd3;
  localparam logic [5:0] C_OFF_CTRL     = 6'd4;
  localparam logic [5:0] C_OFF_PRESCALE = 6'd5;
  localparam logic [5:0] C_OFF_STATUS   = 6'd6;

  logic [63:0] r_mtime;
  logic [63:0] r_cmp;
  logic [1:0]  r_ctrl;        // [1]=IE, [0]=EN
  logic [15:0] r_prescale;
  logic [15:0] r_pre_cnt;
  logic [31:0] r_shadow_hi;
  logic        r_irq;

  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [5:0]  w_off;
  logic        w_sel_any;
  logic        w_wr_mt_lo;
  logic        w_wr_mt_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_tick;
  logic        w_cond;
  logic [15:0] w_pre_cnt_nxt;
  logic [63:0] w_mtime_nxt;
  logic [31:0] w_ctrl_merged;
  logic [31:0] w_pre_merged;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Replace only the byte lanes enabled by sel.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] v_res;
    v_res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) v_res[8*b +: 8] = new_v[8*b +: 8];
    end
    return v_res;
  endfunction

  // Address decode
  assign w_hit     = bus.ce_i && (bus.addr_i[31:8] == BASE_ADDR[31:8]);
  assign w_wr      = w_hit && bus.we_i;
  assign w_rd      = w_hit && !bus.we_i;
  assign w_off     = bus.addr_i[7:2];
  assign w_sel_any = |bus.sel_i;
  assign w_unused  = &{1'b0, bus.addr_i[1:0]};

  // A write with no byte lanes enabled changes nothing, so it neither
  // suppresses the count nor clears the prescaler.
  assign w_wr_mt_lo  = w_wr && w_sel_any && (w_off == C_OFF_MTIME_LO);
  assign w_wr_mt_hi  = w_wr && w_sel_any && (w_off == C_OFF_MTIME_HI);
  assign w_wr_cmp_lo = w_wr && w_sel_any && (w_off == C_OFF_CMP_LO);
  assign w_wr_cmp_hi = w_wr && w_sel_any && (w_off == C_OFF_CMP_HI);
  assign w_wr_ctrl   = w_wr && w_sel_any && (w_off == C_OFF_CTRL);
  assign w_wr_pre    = w_wr && w_sel_any && (w_off == C_OFF_PRESCALE);

  assign w_ctrl_merged = f_merge({30'd0, r_ctrl}, bus.data_i, bus.sel_i);
  assign w_pre_merged  = f_merge({16'd0, r_prescale}, bus.data_i, bus.sel_i);

  assign w_cond = (r_mtime >= r_cmp);

  // Prescaler and counter next-state
  always_comb begin
    w_tick        = r_ctrl[0] && (r_pre_cnt == r_prescale) && !w_wr_pre;
    w_pre_cnt_nxt = r_pre_cnt;
    w_mtime_nxt   = r_mtime;

    if (w_wr_pre) begin
      w_pre_cnt_nxt = 16'd0;
    end else if (r_ctrl[0]) begin
      w_pre_cnt_nxt = w_tick ? 16'd0 : r_pre_cnt + 16'd1;
    end

    // A write to either mtime half wins over the tick for all 64 bits.
    // The prescaler keeps running, so that tick is dropped.
    if (w_wr_mt_lo || w_wr_mt_hi) begin
      if (w_wr_mt_lo) w_mtime_nxt[31:0]  = f_merge(r_mtime[31:0],  bus.data_i, bus.sel_i);
      if (w_wr_mt_hi) w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], bus.data_i, bus.sel_i);
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mtime     <= 64'd0;
      r_cmp       <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_ctrl      <= 2'd0;
      r_prescale  <= PRESCALE_RST;
      r_pre_cnt   <= 16'd0;
      r_shadow_hi <= 32'd0;
      r_irq       <= 1'b0;
    end else begin
      r_mtime   <= w_mtime_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_irq     <= r_ctrl[1] && w_cond;
      if (w_wr_cmp_lo) r_cmp[31:0]  <= f_merge(r_cmp[31:0],  bus.data_i, bus.sel_i);
      if (w_wr_cmp_hi) r_cmp[63:32] <= f_merge(r_cmp[63:32], bus.data_i, bus.sel_i);
      if (w_wr_ctrl)   r_ctrl       <= w_ctrl_merged[1:0];
      if (w_wr_pre)    r_prescale   <= w_pre_merged[15:0];
      // Reading LO captures HI, so a later HI read completes the 64-bit read.
      if (w_rd && (w_off == C_OFF_MTIME_LO)) r_shadow_hi <= r_mtime[63:32];
    end
  end

  // Combinational read mux
  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (w_off)
        C_OFF_MTIME_LO: w_rdata = r_mtime[31:0];
        C_OFF_MTIME_HI: w_rdata = r_shadow_hi;
        C_OFF_CMP_LO:   w_rdata = r_cmp[31:0];
        C_OFF_CMP_HI:   w_rdata = r_cmp[63:32];
        C_OFF_CTRL:     w_rdata = {30'd0, r_ctrl};
        C_OFF_PRESCALE: w_rdata = {16'd0, r_prescale};
        C_OFF_STATUS:   w_rdata = {31'd0, w_cond};
        default:        w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.data_o = w_rdata;
  assign bus.irq_o  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_bitty_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitty_timer
// Description : Self-checking bench for bitty_timer. It runs directed
//               scenarios and then random bus traffic. Each cycle, data_o and
//               irq_o are compared against a behavioural reference model
//               of the register map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitty_timer;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bitty_timer_if bus();

  bitty_timer #(
    .BASE_ADDR    (BASE),
    .PRESCALE_RST (16'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural state of the timer
  logic [63:0] m_mtime  = 64'd0;
  logic [63:0] m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        m_en     = 1'b0;
  logic        m_ie     = 1'b0;
  logic [15:0] m_pre    = 16'd0;
  int unsigned m_phase  = 0;     // enabled cycles since the last increment
  logic [31:0] m_shadow = 32'd0;
  logic        m_irq    = 1'b0;

  function automatic logic [31:0] bytes_in(input logic [31:0] old_v, input logic [31:0] d,
                                           input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] m_read(input logic ce, input logic we, input logic [31:0] a);
    logic [31:0] base_v;
    base_v = BASE;
    if (!ce || we || a[31:8] != base_v[31:8]) return 32'd0;
    case (a[7:0] & 8'hFC)
      8'h00:   return m_mtime[31:0];
      8'h04:   return m_shadow;
      8'h08:   return m_cmp[31:0];
      8'h0C:   return m_cmp[63:32];
      8'h10:   return {30'd0, m_ie, m_en};
      8'h14:   return {16'd0, m_pre};
      8'h18:   return {31'd0, (m_mtime >= m_cmp)};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one clock edge with the given bus request.
  task automatic model_step(input logic ce, input logic we, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d);
    logic [31:0] base_v;
    logic        wr, due;
    logic [7:0]  off;
    logic [63:0] mt;
    logic [31:0] cv;
    base_v = BASE;
    if (!rst) begin
      m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 0; m_ie = 0;
      m_pre = 16'd0; m_phase = 0; m_shadow = 32'd0; m_irq = 0;
      return;
    end
    wr  = ce && we && (a[31:8] == base_v[31:8]) && (s != 4'd0);
    off = a[7:0] & 8'hFC;
    m_irq = m_ie && (m_mtime >= m_cmp);
    if (ce && !we && a[31:8] == base_v[31:8] && off == 8'h00) m_shadow = m_mtime[63:32];
    mt = m_mtime;
    // One increment per (PRESCALE+1) enabled cycles; a PRESCALE write restarts the period.
    due = 1'b0;
    if (wr && off == 8'h14) begin
      m_phase = 0;
    end else if (m_en) begin
      m_phase++;
      if (m_phase >= int'(m_pre) + 1) begin
        due = 1'b1;
        m_phase = 0;
      end
    end
    if (wr && (off == 8'h00 || off == 8'h04)) begin
      if (off == 8'h00) mt[31:0]  = bytes_in(mt[31:0], d, s);
      else              mt[63:32] = bytes_in(mt[63:32], d, s);
    end else if (due) begin
      mt = mt + 64'd1;
    end
    if (wr) begin
      case (off)
        8'h08: m_cmp[31:0]  = bytes_in(m_cmp[31:0], d, s);
        8'h0C: m_cmp[63:32] = bytes_in(m_cmp[63:32], d, s);
        8'h10: begin
          cv = bytes_in({30'd0, m_ie, m_en}, d, s);
          m_en = cv[0];
          m_ie = cv[1];
        end
        8'h14: begin
          cv = bytes_in({16'd0, m_pre}, d, s);
          m_pre = cv[15:0];
        end
        default: ;
      endcase
    end
    m_mtime = mt;
  endtask

  // One bus cycle: drive at negedge, compare outputs, then cross the edge.
  task automatic cycle(input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, output logic [31:0] rdata);
    bus.ce_i = ce; bus.we_i = we; bus.addr_i = a; bus.sel_i = s; bus.data_i = d;
    #1;
    rdata = bus.data_o;
    check("data_o", bus.data_o, m_read(ce, we, a));
    check("irq_o", bus.irq_o, m_irq);
    model_step(ce, we, a, s, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, dummy);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] dummy;
    cycle(1'b1, 1'b1, BASE | {24'd0, off}, s, d, dummy);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    cycle(1'b1, 1'b0, BASE | {24'd0, off}, 4'hF, 32'hDEAD_BEEF, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, lo;
    logic [31:0] exp_rst [8];
    bus.ce_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.sel_i = 0; bus.data_i = 0;
    exp_rst = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};

    // Reset then idle
    rst = 0;
    @(posedge clk); @(negedge clk);
    idle(2);
    rst = 1;
    idle(10);
    for (int i = 0; i < 8; i++) begin
      rd(8'(i * 4), v);
      check("reset_reg", v, exp_rst[i]);
    end
    check("reset_irq", bus.irq_o, 1'b0);

    // PRESCALE=3: one increment every 4 cycles
    wr(8'h14, 32'd3);
    wr(8'h10, 32'd1);
    for (int i = 0; i <= 40; i++) begin
      rd(8'h00, v);
      check("pre3_count", v, 32'(i / 4));
    end

    // Carry from low into high word, shadowed HI
    wr(8'h10, 32'd0);
    wr(8'h00, 32'hFFFF_FFFE);
    wr(8'h04, 32'd0);
    wr(8'h14, 32'd0);
    wr(8'h10, 32'd1);
    idle(3);
    rd(8'h00, v);
    check("carry_lo", v, 32'd1);
    idle(5);
    rd(8'h04, v);
    check("carry_hi_shadow", v, 32'd1);

    // 64-bit wrap to zero
    wr(8'h10, 32'd0);
    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h10, 32'd1);
    idle(1);
    rd(8'h00, v);
    check("wrap_lo", v, 32'd0);
    rd(8'h04, v);
    check("wrap_hi", v, 32'd0);

    // Compare and interrupt timing
    wr(8'h10, 32'd0);
    wr(8'h00, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h08, 32'd20);
    wr(8'h0C, 32'd0);
    wr(8'h14, 32'd0);
    wr(8'h10, 32'd3);
    for (int i = 0; i <= 22; i++) begin
      check("irq_rise", bus.irq_o, i >= 21);
      idle(1);
    end
    wr(8'h08, 32'h100);
    check("irq_hold", bus.irq_o, 1'b1);
    idle(1);
    check("irq_drop", bus.irq_o, 1'b0);

    // Byte-lane write while counting, unmapped offset
    rd(8'h00, lo);
    wr(8'h00, 32'h0000_AB00, 4'b0010);
    rd(8'h00, v);
    check("byte1_write", v, ((lo + 32'd1) & ~32'h0000_FF00) | 32'h0000_AB00);
    wr(8'h1C, 32'h1234_5678);
    rd(8'h1C, v);
    check("unmapped", v, 32'd0);

    // Reset mid-count with irq asserted
    idle(1);
    check("pre_rst_irq", bus.irq_o, 1'b1);
    rst = 0;
    idle(1);
    rst = 1;
    check("post_rst_irq", bus.irq_o, 1'b0);
    rd(8'h00, v);
    check("post_rst_mtime", v, 32'd0);
    idle(3);
    rd(8'h00, v);
    check("post_rst_stopped", v, 32'd0);
    rd(8'h10, v);
    check("post_rst_ctrl", v, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, d;
      logic [7:0]  off;
      logic        we, ce;
      rst = ($urandom_range(0, 199) != 0);
      ce  = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1);
      off = 8'($urandom_range(0, 31));
      a   = BASE | {24'd0, off};
      if ($urandom_range(0, 15) == 0) a = BASE ^ (32'd1 << $urandom_range(8, 31));
      d = $urandom;
      case (off & 8'hFC)
        8'h04: if ($urandom_range(0, 1) != 0) d = m_mtime[63:32];
        8'h08: d = m_mtime[31:0] + 32'($urandom_range(0, 24));
        8'h0C: d = m_mtime[63:32];
        8'h10: d = d | 32'd1;
        8'h14: d = d & 32'h7;
        default: ;
      endcase
      cycle(ce, we, a, 4'($urandom), d, v);
    end
    rst = 1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
